axi4s_packet_gate: RTL and testbench

// Packet-mode counterpart to the word-level AXI4S FIFO: a store-and-forward buffer.
// - Buffers whole packets on the slave side.
// - Releases a packet on the master side only after its tlast beat has been

---
 rtl/axi4s_pkg.sv | 11 +
 rtl/axi4s_packet_gate_ram.sv | 31 +++
 rtl/axi4s_packet_gate.sv | 141 ++++++++++++++
 tb/tb_axi4s_packet_gate.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi4s_pkg.sv
// Shared AXI4-Stream helpers: packet-gate FSM states and a 16-bit status saturator.
package axi4s_pkg;

  typedef enum logic {ST_PASS, ST_DROP} pkt_gate_state_t;

  // Status ports are 16 bits wide; at SIZE=16 the beat count can reach 65536.
  function automatic logic [15:0] sat16(input logic [31:0] v);
    return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
  endfunction

endpackage

// File: rtl/axi4s_packet_gate_ram.sv
// Simple dual-port RAM with registered, enabled read; the read register doubles
// as the packet gate's output register, so it must hold when not enabled.
module axi4s_packet_gate_ram #(
  parameter int WIDTH = 33,
  parameter int SIZE  = 10
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [SIZE-1:0]  i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [SIZE-1:0]  i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [2**SIZE];
  logic [WIDTH-1:0] r_rdata;

  // Write port
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read port: data only changes when a new beat is fetched
  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi4s_packet_gate.sv
// Store-and-forward AXI4-Stream packet gate. Beats are written into a RAM and
// only become readable once their packet's tlast is committed; errored or
// oversized packets are rewound out of the buffer and never reach the output.
module axi4s_packet_gate
  import axi4s_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIZE  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_terror,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [15:0]      space,
  output logic [15:0]      occupied,
  output logic [15:0]      pkt_count,
  output logic             drop_pulse
);

  localparam int PW = SIZE + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {SIZE{1'b0}}};

  pkt_gate_state_t r_state, w_state_nxt;

  // rd_ptr trails the RAM fetch pointer by the beat held in the output register,
  // so that beat still counts as occupied until the consumer takes it.
  logic [PW-1:0] r_wr_ptr, r_commit_ptr, r_rd_ptr, r_raddr;
  logic          r_ovalid, r_drop;
  logic [15:0]   r_pkt_count;

  logic [PW-1:0] w_used;
  logic          w_full, w_ovf, w_tready, w_we, w_commit, w_rewind, w_drop;
  logic          w_load, w_oxfer;
  logic [WIDTH:0] w_rdata;

  assign w_used = r_wr_ptr - r_rd_ptr;
  assign w_full = (w_used == DEPTH);
  // Full with nothing committed: the packet in flight cannot fit at all.
  assign w_ovf  = (r_state == ST_PASS) && w_full && (r_commit_ptr == r_rd_ptr);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst || clear) r_state <= ST_PASS;
    else              r_state <= w_state_nxt;
  end

  // Next state and input-side control
  always_comb begin
    w_state_nxt = r_state;
    w_tready    = 1'b1;
    w_we        = 1'b0;
    w_commit    = 1'b0;
    w_rewind    = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_PASS: begin
        // On the overflow cycle the presented beat is taken and discarded.
        w_tready = !w_full || w_ovf;
        if (w_ovf) begin
          w_rewind = 1'b1;
          w_drop   = 1'b1;
          if (!(i_tvalid && i_tlast)) w_state_nxt = ST_DROP;
        end else if (i_tvalid && !w_full) begin
          w_we = 1'b1;
          if (i_tlast && i_terror) begin
            w_rewind = 1'b1;
            w_drop   = 1'b1;
          end else if (i_tlast) begin
            w_commit = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (i_tvalid && i_tlast) w_state_nxt = ST_PASS;
      end
      default: w_state_nxt = ST_PASS;
    endcase
  end

  assign w_oxfer = r_ovalid && o_tready;
  // Fetch whenever a committed beat is waiting and the output register frees up.
  assign w_load  = (r_raddr != r_commit_ptr) && (!r_ovalid || o_tready);

  // Pointers, output valid, packet count and drop pulse
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_raddr      <= '0;
      r_ovalid     <= 1'b0;
      r_pkt_count  <= '0;
      r_drop       <= 1'b0;
    end else begin
      if (w_rewind)  r_wr_ptr <= r_commit_ptr;
      else if (w_we) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_commit)  r_commit_ptr <= r_wr_ptr + 1'b1;
      if (w_load)    r_raddr <= r_raddr + 1'b1;
      if (w_oxfer)   r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_load)       r_ovalid <= 1'b1;
      else if (w_oxfer) r_ovalid <= 1'b0;
      case ({w_commit, w_oxfer && o_tlast})
        2'b10:   r_pkt_count <= r_pkt_count + 16'd1;
        2'b01:   r_pkt_count <= r_pkt_count - 16'd1;
        default: r_pkt_count <= r_pkt_count;
      endcase
      r_drop <= w_drop;
    end
  end

  axi4s_packet_gate_ram #(
    .WIDTH (WIDTH + 1),
    .SIZE  (SIZE)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr[SIZE-1:0]),
    .i_wdata ({i_tlast, i_tdata}),
    .i_re    (w_load),
    .i_raddr (r_raddr[SIZE-1:0]),
    .o_rdata (w_rdata)
  );

  assign i_tready   = w_tready;
  assign o_tdata    = w_rdata[WIDTH-1:0];
  assign o_tlast    = w_rdata[WIDTH];
  assign o_tvalid   = r_ovalid;
  assign occupied   = sat16(32'(w_used));
  assign space      = sat16(32'(DEPTH - w_used));
  assign pkt_count  = r_pkt_count;
  assign drop_pulse = r_drop;

endmodule

// File: tb/tb_axi4s_packet_gate.sv
// Randomized bench for axi4s_packet_gate: a packet-level scoreboard decides which
// packets must emerge (good, non-oversized) and compares every output beat.
module tb_axi4s_packet_gate;

  localparam int W     = 32;
  localparam int SZ    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, clear;
  logic [W-1:0]  i_tdata;
  logic          i_tlast, i_terror, i_tvalid, i_tready;
  logic [W-1:0]  o_tdata;
  logic          o_tlast, o_tvalid, o_tready;
  logic [15:0]   space, occupied, pkt_count;
  logic          drop_pulse;

  always #5 clk = ~clk;

  axi4s_packet_gate #(.WIDTH(W), .SIZE(SZ)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_terror(i_terror),
    .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .space(space), .occupied(occupied), .pkt_count(pkt_count), .drop_pulse(drop_pulse)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: committed beats {last,data} in order, plus drop tally
  logic [32:0] exp_q[$];
  logic [32:0] cur_q[$];
  int exp_drops = 0, seen_drops = 0;
  int n_out = 0, n_istall = 0;
  int cyc = 0, first_v_cyc = -1, last_acc_cyc = 0;
  bit rdy_rand = 0;
  bit prev_stall = 0;
  logic [32:0] prev_beat;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: scoreboard pop, AXI hold rule, drop and stall tallies
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst || clear) prev_stall = 0;
      else begin
        if (drop_pulse) seen_drops++;
        if (i_tvalid && !i_tready) n_istall++;
        if (prev_stall) begin
          chk("hold_vld", o_tvalid, 1);
          chk("hold_dat", {o_tlast, o_tdata}, prev_beat);
        end
        if (o_tvalid && first_v_cyc < 0) first_v_cyc = cyc;
        if (o_tvalid && o_tready) begin
          if (exp_q.size() == 0) chk("extra_beat", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            chk("out_beat", {o_tlast, o_tdata}, e);
          end
          n_out++;
        end
        prev_stall = o_tvalid && !o_tready;
        prev_beat  = {o_tlast, o_tdata};
      end
    end
  end

  // Random consumer backpressure when enabled
  initial forever begin
    @(posedge clk); #1;
    if (rdy_rand) o_tready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Send one packet; the model keeps it only if good and no longer than the buffer
  // (callers ensure the buffer is drained before an oversized packet).
  task automatic send_pkt(input int len, input bit err, input int gap_pct);
    for (int i = 0; i < len; i++) begin
      logic [31:0] d = $urandom;
      bit last = (i == len - 1);
      bit acc  = 0;
      int t    = 0;
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        i_tvalid = 0; @(posedge clk); #1;
      end
      i_tvalid = 1; i_tdata = d; i_tlast = last;
      i_terror = last ? err : 1'($urandom_range(0, 1));
      do begin
        @(negedge clk);
        acc = i_tready;
        if (acc && last) last_acc_cyc = cyc;
        @(posedge clk); #1;
        t++;
      end while (!acc && t < 1000);
      if (!acc) chk("accept_timeout", acc, 1);
      cur_q.push_back({last, d});
    end
    i_tvalid = 0; i_tlast = 0; i_terror = 0;
    if (err || len > DEPTH) exp_drops++;
    else foreach (cur_q[k]) exp_q.push_back(cur_q[k]);
    cur_q.delete();
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin @(posedge clk); #1; t++; end
    repeat (4) begin @(posedge clk); #1; end
    chk({tag, "_drain"}, exp_q.size(), 0);
    @(negedge clk);
    chk({tag, "_vld_idle"}, o_tvalid, 0);
    chk({tag, "_pktcnt0"}, pkt_count, 0);
    chk({tag, "_occ0"}, occupied, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int base, v, s0, t;
    rst = 1; clear = 0; i_tvalid = 0; i_tdata = 0; i_tlast = 0; i_terror = 0; o_tready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_vld", o_tvalid, 0);
    chk("rst_rdy", i_tready, 1);
    chk("rst_space", space, DEPTH);
    chk("rst_occ", occupied, 0);
    chk("rst_pktcnt", pkt_count, 0);
    chk("rst_drop", drop_pulse, 0);
    @(posedge clk); #1;

    // 1: single 5-beat packet, latency and count
    base = n_out;
    send_pkt(5, 0, 0);
    @(negedge clk);
    chk("t1_pktcnt1", pkt_count, 1);
    @(posedge clk); #1;
    drain("t1");
    chk("t1_latency", first_v_cyc - last_acc_cyc, 2);
    chk("t1_beats", n_out - base, 5);

    // 2: errored packet then good packet
    base = n_out;
    send_pkt(3, 1, 0);
    send_pkt(2, 0, 0);
    drain("t2");
    chk("t2_beats", n_out - base, 2);
    chk("t2_drops", seen_drops, exp_drops);

    // 3: oversized packet, never stalls input, then a normal packet
    base = n_out; s0 = n_istall;
    send_pkt(20, 0, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("t3_no_out", n_out - base, 0);
    chk("t3_no_stall", n_istall - s0, 0);
    chk("t3_drops", seen_drops, exp_drops);
    send_pkt(4, 0, 0);
    drain("t3");
    chk("t3_beats", n_out - base, 4);

    // 4: fill with three packets under backpressure, then stream
    base = n_out;
    o_tready = 0;
    for (int p = 0; p < 3; p++) send_pkt(4, 0, 0);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("t4_pktcnt3", pkt_count, 3);
    chk("t4_space4", space, 4);
    @(posedge clk); #1;
    o_tready = 1;
    v = 0;
    repeat (12) begin @(negedge clk); if (o_tvalid) v++; end
    chk("t4_no_bubble", v, 12);
    @(posedge clk); #1;
    drain("t4");
    chk("t4_beats", n_out - base, 12);

    // 5: random traffic with backpressure and pointer wrap
    rdy_rand = 1;
    for (int p = 0; p < 100; p++)
      send_pkt($urandom_range(1, 16), $urandom_range(0, 7) == 0, 20);
    rdy_rand = 0;
    @(posedge clk); #1;
    o_tready = 1;
    drain("t5");
    chk("t5_drops", seen_drops, exp_drops);

    // 6: clear during output of a 6-beat packet
    base = n_out;
    send_pkt(6, 0, 0);
    t = 0;
    while (n_out - base < 3 && t < 100) begin @(posedge clk); #1; t++; end
    chk("t6_started", n_out - base, 3);
    clear = 1;
    @(posedge clk); #1;
    clear = 0;
    exp_q.delete();
    @(negedge clk);
    chk("t6_vld", o_tvalid, 0);
    chk("t6_pktcnt", pkt_count, 0);
    chk("t6_space", space, DEPTH);
    @(posedge clk); #1;
    base = n_out;
    send_pkt(4, 0, 0);
    drain("t6");
    chk("t6_beats", n_out - base, 4);
    chk("final_drops", seen_drops, exp_drops);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
